// File: rtl/aclk_defs.sv
// Shared definitions for the alarm-clock time-of-day path: BCD digit width,
// per-digit limits and the default seconds-per-minute count.
package aclk_defs;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MAX_LS_DIGIT   = 4'd9;
    localparam bcd_t MAX_MS_MIN     = 4'd5;
    localparam bcd_t MAX_MS_HR      = 4'd2;
    localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;

    localparam int DEFAULT_SECS_PER_MIN = 60;

endpackage

// File: rtl/aclk_time_counter_bcd_digit.sv
// One BCD digit register: synchronous load, forced wrap to zero, and an
// increment enable that rolls over at a programmable terminal value.
module aclk_bcd_digit
    import aclk_defs::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic wrap,
    input  logic load,
    input  bcd_t load_value,
    input  bcd_t terminal,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_reg;
    bcd_t digit_next;

    assign carry_out = en && (digit_reg == terminal);

    // Load beats wrap beats increment; the top never asserts load with the others.
    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = load_value;
        end else if (wrap) begin
            digit_next = '0;
        end else if (en) begin
            digit_next = (digit_reg == terminal) ? '0 : digit_reg + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_reg <= '0;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit = digit_reg;

endmodule

// File: rtl/aclk_time_counter.sv
// 24-hour HH:MM BCD time-of-day counter driven by a one-second tick, with
// validated user load, a minute-rollover pulse and a rejected-load pulse.
module aclk_time_counter
    import aclk_defs::*;
#(
    parameter int SECS_PER_MIN = DEFAULT_SECS_PER_MIN
) (
    input  logic clock,
    input  logic reset,
    input  logic one_second,
    input  logic load_new_c,
    input  bcd_t new_ms_hr,
    input  bcd_t new_ls_hr,
    input  bcd_t new_ms_min,
    input  bcd_t new_ls_min,
    output bcd_t current_ms_hr,
    output bcd_t current_ls_hr,
    output bcd_t current_ms_min,
    output bcd_t current_ls_min,
    output logic minute_tick,
    output logic load_error
);

    localparam int SEC_W = (SECS_PER_MIN > 1) ? $clog2(SECS_PER_MIN) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_MIN - 1);

    logic             load_valid;
    logic             do_load;
    logic             load_reject;
    logic             sec_tick;
    logic             sec_wrap;
    logic [SEC_W-1:0] sec_reg;
    logic [SEC_W-1:0] sec_next;
    logic             minute_tick_reg;
    logic             load_error_reg;

    logic ls_min_carry;
    logic ms_min_carry;
    logic ls_hr_carry;
    logic ms_hr_carry;
    logic at_23;
    logic hour_en;
    logic hour_wrap;

    // Hours 20-23 are legal only when the tens digit is 2 and units are 0-3.
    assign load_valid = (new_ls_min <= MAX_LS_DIGIT) &&
                        (new_ms_min <= MAX_MS_MIN)   &&
                        (new_ls_hr  <= MAX_LS_DIGIT) &&
                        ((new_ms_hr < MAX_MS_HR) ||
                         ((new_ms_hr == MAX_MS_HR) && (new_ls_hr <= MAX_LS_HR_AT_2)));

    assign do_load     = load_new_c && load_valid;
    assign load_reject = load_new_c && !load_valid;
    // A valid load swallows a coincident tick; a rejected one does not.
    assign sec_tick    = one_second && !do_load;
    assign sec_wrap    = sec_tick && (sec_reg == SEC_LAST);

    always_comb begin
        sec_next = sec_reg;
        if (do_load || sec_wrap) begin
            sec_next = '0;
        end else if (sec_tick) begin
            sec_next = sec_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sec_reg         <= '0;
            minute_tick_reg <= 1'b0;
            load_error_reg  <= 1'b0;
        end else begin
            sec_reg         <= sec_next;
            minute_tick_reg <= sec_wrap;
            load_error_reg  <= load_reject;
        end
    end

    assign at_23     = (current_ms_hr == MAX_MS_HR) && (current_ls_hr == MAX_LS_HR_AT_2);
    assign hour_en   = ms_min_carry && !at_23;
    // Any hour overflow, including an unreachable tens-digit carry, returns to 00.
    assign hour_wrap = (ms_min_carry && at_23) || ms_hr_carry;

    aclk_bcd_digit u_ls_min (
        .clock      (clock),
        .reset      (reset),
        .en         (sec_wrap),
        .wrap       (1'b0),
        .load       (do_load),
        .load_value (new_ls_min),
        .terminal   (MAX_LS_DIGIT),
        .digit      (current_ls_min),
        .carry_out  (ls_min_carry)
    );

    aclk_bcd_digit u_ms_min (
        .clock      (clock),
        .reset      (reset),
        .en         (ls_min_carry),
        .wrap       (1'b0),
        .load       (do_load),
        .load_value (new_ms_min),
        .terminal   (MAX_MS_MIN),
        .digit      (current_ms_min),
        .carry_out  (ms_min_carry)
    );

    aclk_bcd_digit u_ls_hr (
        .clock      (clock),
        .reset      (reset),
        .en         (hour_en),
        .wrap       (hour_wrap),
        .load       (do_load),
        .load_value (new_ls_hr),
        .terminal   (MAX_LS_DIGIT),
        .digit      (current_ls_hr),
        .carry_out  (ls_hr_carry)
    );

    aclk_bcd_digit u_ms_hr (
        .clock      (clock),
        .reset      (reset),
        .en         (ls_hr_carry),
        .wrap       (hour_wrap),
        .load       (do_load),
        .load_value (new_ms_hr),
        .terminal   (MAX_MS_HR),
        .digit      (current_ms_hr),
        .carry_out  (ms_hr_carry)
    );

    assign minute_tick = minute_tick_reg;
    assign load_error  = load_error_reg;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: minutes-of-day reference model checked every
// cycle, plus directed scenarios with literal expected times.
module tb_aclk_time_counter;

    localparam int SPM = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] new_ms_hr = '0;
    logic [3:0] new_ls_hr = '0;
    logic [3:0] new_ms_min = '0;
    logic [3:0] new_ls_min = '0;
    logic [3:0] current_ms_hr;
    logic [3:0] current_ls_hr;
    logic [3:0] current_ms_min;
    logic [3:0] current_ls_min;
    logic       minute_tick;
    logic       load_error;

    int checks = 0;
    int failures = 0;

    aclk_time_counter #(.SECS_PER_MIN(SPM)) dut (
        .clock          (clock),
        .reset          (reset),
        .one_second     (one_second),
        .load_new_c     (load_new_c),
        .new_ms_hr      (new_ms_hr),
        .new_ls_hr      (new_ls_hr),
        .new_ms_min     (new_ms_min),
        .new_ls_min     (new_ls_min),
        .current_ms_hr  (current_ms_hr),
        .current_ls_hr  (current_ls_hr),
        .current_ms_min (current_ms_min),
        .current_ls_min (current_ls_min),
        .minute_tick    (minute_tick),
        .load_error     (load_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: time as minutes since midnight, seconds as a plain count.
    int m_minutes = 0;
    int m_seconds = 0;
    bit m_tick = 0;
    bit m_err = 0;

    function automatic bit time_ok(input int mh, input int lh, input int mm, input int lm);
        return (lm <= 9) && (mm <= 5) && (lh <= 9) && ((mh * 10 + lh) <= 23);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_minutes <= 0;
            m_seconds <= 0;
            m_tick    <= 0;
            m_err     <= 0;
        end else if (load_new_c && time_ok(new_ms_hr, new_ls_hr, new_ms_min, new_ls_min)) begin
            m_minutes <= (int'(new_ms_hr) * 10 + int'(new_ls_hr)) * 60
                         + int'(new_ms_min) * 10 + int'(new_ls_min);
            m_seconds <= 0;
            m_tick    <= 0;
            m_err     <= 0;
        end else begin
            m_err  <= load_new_c;
            m_tick <= 0;
            if (one_second) begin
                if (m_seconds + 1 == SPM) begin
                    m_seconds <= 0;
                    m_minutes <= (m_minutes + 1) % 1440;
                    m_tick    <= 1;
                end else begin
                    m_seconds <= m_seconds + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        int hh;
        int mm;
        hh = m_minutes / 60;
        mm = m_minutes % 60;
        check("model_ms_hr",  int'(current_ms_hr),  hh / 10);
        check("model_ls_hr",  int'(current_ls_hr),  hh % 10);
        check("model_ms_min", int'(current_ms_min), mm / 10);
        check("model_ls_min", int'(current_ls_min), mm % 10);
        check("model_minute_tick", int'(minute_tick), int'(m_tick));
        check("model_load_error",  int'(load_error),  int'(m_err));
    end

    task automatic drive(input bit os, input bit ld, input int a, input int b,
                         input int c, input int d);
        @(posedge clock);
        #2;
        one_second = os;
        load_new_c = ld;
        new_ms_hr  = 4'(a);
        new_ls_hr  = 4'(b);
        new_ms_min = 4'(c);
        new_ls_min = 4'(d);
    endtask

    // Return inputs to idle and sample the result of the last driven cycle.
    task automatic settle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_time(input string name, input int hhmm);
        int got;
        got = int'(current_ms_hr) * 1000 + int'(current_ls_hr) * 100
            + int'(current_ms_min) * 10 + int'(current_ls_min);
        check(name, got, hhmm);
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d);
        drive(0, 1, a, b, c, d);
        settle();
    endtask

    typedef struct { int a; int b; int c; int d; } load_vec_t;
    load_vec_t bad_loads [3];
    load_vec_t chain_loads [3];
    int chain_expect [3];

    initial begin
        bad_loads[0] = '{2, 4, 0, 0};
        bad_loads[1] = '{1, 2, 6, 0};
        bad_loads[2] = '{0, 10, 0, 0};
        chain_loads[0] = '{2, 3, 5, 9};
        chain_loads[1] = '{0, 9, 5, 9};
        chain_loads[2] = '{1, 9, 5, 9};
        chain_expect[0] = 0;
        chain_expect[1] = 1000;
        chain_expect[2] = 2000;

        repeat (3) @(negedge clock);
        expect_time("reset_time", 0);
        check("reset_minute_tick", int'(minute_tick), 0);
        check("reset_load_error", int'(load_error), 0);
        $display("txn reset held: time %0d%0d:%0d%0d", current_ms_hr, current_ls_hr,
                 current_ms_min, current_ls_min);

        @(posedge clock);
        #2 reset = 1'b1;
        ticks(SPM);
        settle();
        expect_time("first_minute", 1);
        check("first_minute_tick", int'(minute_tick), 1);
        @(negedge clock);
        check("first_minute_tick_width", int'(minute_tick), 0);
        $display("txn %0d ticks after reset -> 00:01", SPM);

        for (int i = 0; i < 3; i++) begin
            do_load(chain_loads[i].a, chain_loads[i].b, chain_loads[i].c, chain_loads[i].d);
            ticks(SPM - 1);
            settle();
            check("chain_no_early_tick", int'(minute_tick), 0);
            ticks(1);
            settle();
            expect_time("chain_rollover", chain_expect[i]);
            check("chain_tick", int'(minute_tick), 1);
            $display("txn load %0d%0d:%0d%0d + 1 min -> %04d", chain_loads[i].a, chain_loads[i].b,
                     chain_loads[i].c, chain_loads[i].d, chain_expect[i]);
        end

        for (int i = 0; i < 3; i++) begin
            do_load(bad_loads[i].a, bad_loads[i].b, bad_loads[i].c, bad_loads[i].d);
            expect_time("bad_load_unchanged", 2000);
            check("bad_load_error", int'(load_error), 1);
            @(negedge clock);
            check("bad_load_error_width", int'(load_error), 0);
            $display("txn invalid load %0d,%0d,%0d,%0d rejected", bad_loads[i].a,
                     bad_loads[i].b, bad_loads[i].c, bad_loads[i].d);
        end

        drive(1, 1, 2, 4, 0, 0);
        settle();
        check("bad_load_with_tick_error", int'(load_error), 1);
        $display("txn invalid load with coincident tick");

        do_load(0, 0, 0, 0);
        ticks(SPM - 1);
        drive(1, 1, 1, 2, 3, 4);
        settle();
        expect_time("collision_load", 1234);
        check("collision_no_tick", int'(minute_tick), 0);
        ticks(SPM - 1);
        settle();
        expect_time("collision_partial", 1234);
        ticks(1);
        settle();
        expect_time("collision_full_minute", 1235);
        check("collision_later_tick", int'(minute_tick), 1);
        $display("txn load/tick collision -> 12:34, rollover after %0d ticks", SPM);

        do_load(1, 2, 3, 4);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        expect_time("async_reset_time", 0);
        $display("txn async reset between edges -> 00:00");
        @(posedge clock);
        #2 reset = 1'b1;
        settle();
        expect_time("after_reset_release", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
